axis_width_downsizer: RTL and testbench

- Sits directly downstream of the 64-bit AXI-Stream FIFO.
- Splits each accepted IN_WIDTH beat into IN_WIDTH/OUT_WIDTH narrower words, one per output handshake, for the transpose-convolution datapath.
- Carries beat tlast through to the final lane only.
- Sustains one output word per cycle across back-to-back beats, with no bubble at beat boundaries.

---
 rtl/axis_width_downsizer.sv | 117 +++++++++++
 tb/tb_axis_width_downsizer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_width_downsizer.sv
// AXI-Stream width downsizer: splits each IN_WIDTH beat into IN_WIDTH/OUT_WIDTH words, tlast on the final lane only.
// Optional per-packet word and packet statistics are compiled in with `define DOWNSIZER_STATS_EN.
module axis_width_downsizer #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16,
    parameter int LSB_FIRST = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 s_aclk,
    input  logic                 s_aresetn,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                 s_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tlast,
    output logic                 busy
`ifdef DOWNSIZER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] word_count,
    output logic [CNT_WIDTH-1:0] pkt_count
`endif
);

    localparam int LANES  = IN_WIDTH / OUT_WIDTH;
    localparam int LANE_W = $clog2(LANES);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    if ((IN_WIDTH % OUT_WIDTH) != 0 || LANES < 2 || CNT_WIDTH < 1) begin : g_badParams
        $error("axis_width_downsizer: invalid IN_WIDTH/OUT_WIDTH/CNT_WIDTH combination");
    end

    logic [0:0]          r_state;
    logic [LANE_W-1:0]   r_lane;
    logic [IN_WIDTH-1:0] r_holdData;
    logic                r_holdLast;

    logic                 w_lastLane;
    logic                 w_accept;
    logic                 w_emit;
    logic [LANE_W-1:0]    w_sliceIdx;
    logic [OUT_WIDTH-1:0] w_sliceData;

    assign w_lastLane = (r_lane == LANE_W'(LANES - 1));

    // Ready depends only on registered state and the downstream ready, never on s_axis_tvalid.
    assign s_axis_tready = s_aresetn && ((r_state == EMPTY) || (w_lastLane && m_axis_tready));

    assign w_accept = s_axis_tvalid && s_axis_tready;
    assign w_emit   = m_axis_tvalid && m_axis_tready;

    assign w_sliceIdx = (LSB_FIRST != 0) ? r_lane : (LANE_W'(LANES - 1) - r_lane);

    always_comb begin
        w_sliceData = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_sliceIdx == LANE_W'(i)) begin
                w_sliceData = r_holdData[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    assign m_axis_tvalid = (r_state == HOLD);
    assign m_axis_tdata  = w_sliceData;
    assign m_axis_tlast  = r_holdLast && w_lastLane;
    assign busy          = m_axis_tvalid;

    // An accept on the final lane reloads the register in the same cycle, so beats stream without a bubble.
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            r_state    <= EMPTY;
            r_lane     <= '0;
            r_holdData <= '0;
            r_holdLast <= 1'b0;
        end else if (w_accept) begin
            r_state    <= HOLD;
            r_lane     <= '0;
            r_holdData <= s_axis_tdata;
            r_holdLast <= s_axis_tlast;
        end else if (w_emit) begin
            if (w_lastLane) begin
                r_state <= EMPTY;
                r_lane  <= '0;
            end else begin
                r_lane <= r_lane + 1'b1;
            end
        end
    end

`ifdef DOWNSIZER_STATS_EN
    logic [CNT_WIDTH-1:0] r_wordCount;
    logic [CNT_WIDTH-1:0] r_pktCount;

    // The tlast handshake closes the packet, so it clears the word count instead of incrementing it.
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            r_wordCount <= '0;
            r_pktCount  <= '0;
        end else if (w_emit) begin
            if (m_axis_tlast) begin
                r_wordCount <= '0;
                r_pktCount  <= r_pktCount + 1'b1;
            end else begin
                r_wordCount <= r_wordCount + 1'b1;
            end
        end
    end

    assign word_count = r_wordCount;
    assign pkt_count  = r_pktCount;
`endif

endmodule

// File: tb/tb_axis_width_downsizer.sv
// Directed bench for axis_width_downsizer: an LSB-first instance for streaming, stall and reset cases,
// plus an MSB-first instance for lane ordering; statistics are checked when DOWNSIZER_STATS_EN is defined.
module tb_axis_width_downsizer;

    localparam int IW    = 64;
    localparam int OW    = 16;
    localparam int LANES = IW / OW;
`ifdef DOWNSIZER_STATS_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic s_aclk    = 1'b0;
    logic s_aresetn = 1'b0;

    always #5 s_aclk = ~s_aclk;

    logic          sTvalid, sTready, sTlast;
    logic [IW-1:0] sTdata;
    logic          mTvalid, mTready, mTlast, busyA;
    logic [OW-1:0] mTdata;

    logic          bSTvalid, bSTready, bSTlast;
    logic [IW-1:0] bSTdata;
    logic          bMTvalid, bMTready, bMTlast, busyB;
    logic [OW-1:0] bMTdata;

`ifdef DOWNSIZER_STATS_EN
    logic [CW-1:0] wordCount, pktCount, bWordCount, bPktCount;
`endif

    axis_width_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LSB_FIRST(1), .CNT_WIDTH(CW)) dut (
        .s_aclk        (s_aclk),
        .s_aresetn     (s_aresetn),
        .s_axis_tvalid (sTvalid),
        .s_axis_tready (sTready),
        .s_axis_tdata  (sTdata),
        .s_axis_tlast  (sTlast),
        .m_axis_tvalid (mTvalid),
        .m_axis_tready (mTready),
        .m_axis_tdata  (mTdata),
        .m_axis_tlast  (mTlast),
        .busy          (busyA)
`ifdef DOWNSIZER_STATS_EN
        ,
        .word_count    (wordCount),
        .pkt_count     (pktCount)
`endif
    );

    axis_width_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LSB_FIRST(0), .CNT_WIDTH(CW)) dutMsb (
        .s_aclk        (s_aclk),
        .s_aresetn     (s_aresetn),
        .s_axis_tvalid (bSTvalid),
        .s_axis_tready (bSTready),
        .s_axis_tdata  (bSTdata),
        .s_axis_tlast  (bSTlast),
        .m_axis_tvalid (bMTvalid),
        .m_axis_tready (bMTready),
        .m_axis_tdata  (bMTdata),
        .m_axis_tlast  (bMTlast),
        .busy          (busyB)
`ifdef DOWNSIZER_STATS_EN
        ,
        .word_count    (bWordCount),
        .pkt_count     (bPktCount)
`endif
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Every comparison in the bench funnels through here so the summary counts stay honest.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Lane i of beat b carries word base + (LANES*b + i)*step, so output word k should be base + k*step.
    function automatic logic [IW-1:0] beatData(input int base, input int step, input int b);
        logic [IW-1:0] d;
        d = '0;
        for (int i = 0; i < LANES; i++) begin
            d[i*OW +: OW] = OW'(base + (LANES*b + i)*step);
        end
        return d;
    endfunction

    // Streams nBeats into the LSB-first instance and checks every output word as it is offered.
    task automatic applyStimulus(input int nBeats, input int base, input int step, input bit lastOnFinal,
                                 input bit randomReady, input bit checkGapless);
        int total;
        int beatIdx;
        int wordIdx;
        int cycles;
        int c0;
        logic prevStall;
        logic [OW-1:0] prevData;
        total     = nBeats * LANES;
        beatIdx   = 0;
        wordIdx   = 0;
        cycles    = 0;
        c0        = -1;
        prevStall = 1'b0;
        prevData  = '0;
        while (wordIdx < total && cycles < 2000) begin
            sTvalid = (beatIdx < nBeats);
            sTdata  = (beatIdx < nBeats) ? beatData(base, step, beatIdx) : '0;
            sTlast  = lastOnFinal && (beatIdx == nBeats - 1);
            mTready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge s_aclk);
            if (c0 >= 0 && cycles == c0 + 1) checkOutput("first_word_latency", 64'(mTvalid), 64'd1);
            if (prevStall) begin
                checkOutput("valid_held_in_stall", 64'(mTvalid), 64'd1);
                checkOutput("data_stable_in_stall", 64'(mTdata), 64'(prevData));
            end
            if (checkGapless && wordIdx > 0) checkOutput("no_gap", 64'(mTvalid), 64'd1);
            if (checkGapless && c0 >= 0) checkOutput("s_tready_pattern", 64'(sTready), 64'(((cycles - c0) % LANES) == 0));
            if (mTvalid) begin
                checkOutput("word_data", 64'(mTdata), 64'(OW'(base + wordIdx*step)));
                checkOutput("word_last", 64'(mTlast), 64'(lastOnFinal && (wordIdx == total - 1)));
                checkOutput("busy", 64'(busyA), 64'd1);
            end
`ifdef DOWNSIZER_STATS_EN
            checkOutput("word_count", 64'(wordCount), 64'(CW'(wordIdx)));
`endif
            prevStall = mTvalid && !mTready;
            prevData  = mTdata;
            if (mTvalid && mTready) wordIdx++;
            if (sTvalid && sTready) begin
                if (c0 < 0) c0 = cycles;
                beatIdx++;
            end
            @(posedge s_aclk);
            #1;
            cycles++;
        end
        sTvalid = 1'b0;
        sTlast  = 1'b0;
        mTready = 1'b1;
        checkOutput("stream_complete", 64'(wordIdx), 64'(total));
        checkOutput("drained", 64'(mTvalid), 64'd0);
    endtask

    task automatic pulseReset();
        @(negedge s_aclk);
        s_aresetn = 1'b0;
        @(posedge s_aclk);
        @(negedge s_aclk);
        s_aresetn = 1'b1;
        @(posedge s_aclk);
        #1;
    endtask

    logic [OW-1:0] msbExp [LANES] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};

    initial begin
        sTvalid  = 1'b0; sTdata  = '0; sTlast  = 1'b0; mTready  = 1'b0;
        bSTvalid = 1'b0; bSTdata = '0; bSTlast = 1'b0; bMTready = 1'b0;

        // Outputs while reset is held.
        repeat (2) @(posedge s_aclk);
        #1;
        checkOutput("reset_m_tvalid", 64'(mTvalid), 64'd0);
        checkOutput("reset_s_tready", 64'(sTready), 64'd0);
        checkOutput("reset_m_tdata", 64'(mTdata), 64'd0);
        checkOutput("reset_m_tlast", 64'(mTlast), 64'd0);
        checkOutput("reset_busy", 64'(busyA), 64'd0);
`ifdef DOWNSIZER_STATS_EN
        checkOutput("reset_word_count", 64'(wordCount), 64'd0);
        checkOutput("reset_pkt_count", 64'(pktCount), 64'd0);
`endif
        @(negedge s_aclk);
        s_aresetn = 1'b1;
        @(posedge s_aclk);
        #1;
        checkOutput("ready_after_reset", 64'(sTready), 64'd1);

        // Single beat 0x4444_3333_2222_1111 with tlast.
        applyStimulus(1, 16'h1111, 16'h1111, 1'b1, 1'b0, 1'b1);
`ifdef DOWNSIZER_STATS_EN
        checkOutput("single_pkt_count", 64'(pktCount), 64'd1);
        checkOutput("single_word_count", 64'(wordCount), 64'd0);
`endif

        // Three back-to-back beats at full rate.
        applyStimulus(3, 16'h0100, 1, 1'b1, 1'b0, 1'b1);
`ifdef DOWNSIZER_STATS_EN
        checkOutput("b2b_pkt_count", 64'(pktCount), 64'd2);
`endif

        // 32-beat packet under random backpressure.
        applyStimulus(32, 16'h2000, 1, 1'b1, 1'b1, 1'b0);
`ifdef DOWNSIZER_STATS_EN
        checkOutput("long_pkt_count", 64'(pktCount), 64'd3);
        checkOutput("long_word_count", 64'(wordCount), 64'd0);
`endif

        // MSB-first lane ordering.
        bSTvalid = 1'b1; bSTdata = 64'hAAAA_BBBB_CCCC_DDDD; bSTlast = 1'b1; bMTready = 1'b1;
        @(negedge s_aclk);
        checkOutput("msb_accept_ready", 64'(bSTready), 64'd1);
        @(posedge s_aclk);
        #1;
        bSTvalid = 1'b0; bSTlast = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            @(negedge s_aclk);
            checkOutput("msb_valid", 64'(bMTvalid), 64'd1);
            checkOutput("msb_data", 64'(bMTdata), 64'(msbExp[i]));
            checkOutput("msb_last", 64'(bMTlast), 64'(i == LANES - 1));
            @(posedge s_aclk);
            #1;
        end
        checkOutput("msb_drained", 64'(bMTvalid), 64'd0);

        // Asynchronous reset in the middle of a beat.
        sTvalid = 1'b1; sTdata = 64'h0004_0003_0002_0001; sTlast = 1'b1; mTready = 1'b1;
        @(posedge s_aclk);
        #1;
        sTvalid = 1'b0; sTlast = 1'b0;
        repeat (2) begin
            @(posedge s_aclk);
            #1;
        end
        checkOutput("pre_reset_lane2", 64'(mTdata), 64'h0003);
        #2;
        s_aresetn = 1'b0;
        #1;
        checkOutput("async_reset_m_tvalid", 64'(mTvalid), 64'd0);
        checkOutput("async_reset_busy", 64'(busyA), 64'd0);
        checkOutput("async_reset_s_tready", 64'(sTready), 64'd0);
        @(posedge s_aclk);
        @(negedge s_aclk);
        s_aresetn = 1'b1;
        @(posedge s_aclk);
        #1;
        checkOutput("post_reset_m_tvalid", 64'(mTvalid), 64'd0);
        checkOutput("post_reset_s_tready", 64'(sTready), 64'd1);
        applyStimulus(1, 5, 1, 1'b1, 1'b0, 1'b1);
        repeat (3) @(posedge s_aclk);
        #1;
        checkOutput("no_leftover", 64'(mTvalid), 64'd0);

`ifdef DOWNSIZER_STATS_EN
        // Seventeen one-beat packets wrap the 4-bit packet counter to 1.
        pulseReset();
        for (int p = 0; p < 17; p++) begin
            applyStimulus(1, p * LANES, 1, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("wrap_pkt_count", 64'(pktCount), 64'd1);
        checkOutput("wrap_word_count", 64'(wordCount), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
